// File: rtl/down_count_monitor_pkg.sv
// Shared types and helpers for the down-counter monitor.
package down_count_monitor_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 4;
    localparam int unsigned DEFAULT_PERIOD_W = 8;

    // Checker state encoding, also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } mon_state_t;

    // Terminal (reload) value of a down counter of the given width.
    function automatic logic [31:0] count_all_ones(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/down_count_monitor_evt_hold_reg.sv
// One-deep valid/ready holding register with a sticky drop (overflow) flag.
module evt_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ready,
    input  logic              clr,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ovf
);

    logic load_c;
    logic drop_c;

    // A new event fits when the slot is empty or being drained this cycle.
    always_comb begin
        load_c = push & (~valid | ready);
        drop_c = push & valid & ~ready;
    end

    // Slot contents: load wins over drain; data only changes on a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load_c) begin
            valid <= 1'b1;
            data  <= push_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky overflow; a drop on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/down_count_monitor.sv
// Step checker, wrap detector and period counter for a down counter.
module down_count_monitor
    import down_count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_en,
    input  logic [WIDTH-1:0]    count,
    input  logic                clr_err,
    input  logic                evt_ready,
    output logic                evt_valid,
    output logic [PERIOD_W-1:0] evt_data,
    output logic                tc_pulse,
    output logic [PERIOD_W-1:0] wrap_count,
    output logic                seq_err,
    output logic                ovf,
    output logic [1:0]          state
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(count_all_ones(WIDTH));

    mon_state_t           state_q;
    mon_state_t           state_d;
    logic [WIDTH-1:0]     cnt_q;
    logic                 en_q;
    logic [WIDTH-1:0]     expected_c;
    logic                 mismatch_c;
    logic                 wrap_c;
    logic [PERIOD_W-1:0]  wrap_count_d;

    // Step check and next-state decode; checks only run while tracking.
    always_comb begin
        state_d      = state_q;
        mismatch_c   = 1'b0;
        wrap_c       = 1'b0;
        expected_c   = en_q ? (cnt_q - WIDTH'(1)) : cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = TRACK;
            end
            TRACK: begin
                if (count != expected_c) begin
                    mismatch_c = 1'b1;
                    state_d    = FAULT;
                end else if (en_q && (cnt_q == '0) && (count == ALL_ONES)) begin
                    wrap_c = 1'b1;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wrap_count_d = wrap_c ? (wrap_count + PERIOD_W'(1)) : wrap_count;
    end

    // Checker state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample history, wrap pulse and period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            en_q       <= 1'b0;
            tc_pulse   <= 1'b0;
            wrap_count <= '0;
        end else begin
            cnt_q      <= count;
            en_q       <= cnt_en;
            tc_pulse   <= wrap_c;
            wrap_count <= wrap_count_d;
        end
    end

    // Sticky sequence error; a mismatch beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err <= 1'b0;
        end else if (mismatch_c) begin
            seq_err <= 1'b1;
        end else if (clr_err) begin
            seq_err <= 1'b0;
        end
    end

    // Each wrap offers its new period count to the consumer.
    evt_hold_reg #(
        .DATA_W (PERIOD_W)
    ) u_evt_hold_reg (
        .clk       (clk),
        .rst       (rst),
        .push      (wrap_c),
        .push_data (wrap_count_d),
        .ready     (evt_ready),
        .clr       (clr_err),
        .valid     (evt_valid),
        .data      (evt_data),
        .ovf       (ovf)
    );

    assign state = state_q;

endmodule
